// File: rtl/branch_target_predictor.sv
`default_nettype none
// branch_target_predictor: direct-mapped BTB with per-entry saturating counters.
// Optional STATS_EN macro builds resolved-branch / misprediction counters.  Rev 1.0
module branch_target_predictor #(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_f,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_pred_taken,
  input  logic [WIDTH-1:0] upd_pred_target,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_ALLOC - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;

  logic                valid_tbl  [ENTRIES];
  logic [TAG_W-1:0]    tag_tbl    [ENTRIES];
  logic [WIDTH-1:0]    target_tbl [ENTRIES];
  logic [CTR_BITS-1:0] ctr_tbl    [ENTRIES];

  logic [IDX-1:0]   idx_f, idx_u;
  logic [TAG_W-1:0] tag_f, tag_u;
  logic             hit_f, hit_u, mispred_raw;
  logic             unused_bits;

  assign idx_f = pc_f[IDX+1:2];
  assign tag_f = pc_f[WIDTH-1:IDX+2];
  assign idx_u = upd_pc[IDX+1:2];
  assign tag_u = upd_pc[WIDTH-1:IDX+2];
  assign unused_bits = &{1'b0, pc_f[1:0], upd_pc[1:0]};

  // Lookup reads pre-edge state only; same-cycle updates are not bypassed.
  assign hit_f       = valid_tbl[idx_f] && (tag_tbl[idx_f] == tag_f);
  assign hit_u       = valid_tbl[idx_u] && (tag_tbl[idx_u] == tag_u);
  assign pred_valid  = rst & hit_f;
  assign pred_taken  = pred_valid & ctr_tbl[idx_f][CTR_BITS-1];
  assign pred_target = pred_valid ? target_tbl[idx_f] : '0;

  assign mispred_raw = upd_valid &
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign mispredict  = rst & mispred_raw;
  assign redirect_pc = !rst     ? '0 :
                       upd_taken ? upd_target : upd_pc + WIDTH'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_tbl[i]  <= 1'b0;
        tag_tbl[i]    <= '0;
        target_tbl[i] <= '0;
        ctr_tbl[i]    <= CTR_RST;
      end
    end else if (upd_valid) begin
      if (hit_u) begin
        if (upd_taken) begin
          if (ctr_tbl[idx_u] != CTR_MAX) ctr_tbl[idx_u] <= ctr_tbl[idx_u] + CTR_BITS'(1);
          target_tbl[idx_u] <= upd_target;
        end else if (ctr_tbl[idx_u] != '0) begin
          ctr_tbl[idx_u] <= ctr_tbl[idx_u] - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        // Miss (including alias) on a taken branch replaces the entry.
        valid_tbl[idx_u]  <= 1'b1;
        tag_tbl[idx_u]    <= tag_u;
        target_tbl[idx_u] <= upd_target;
        ctr_tbl[idx_u]    <= CTR_ALLOC;
      end
    end
  end

`ifdef STATS_EN
  logic [31:0] branch_q, mispred_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      if (upd_valid && (branch_q != '1))    branch_q  <= branch_q + 32'd1;
      if (mispred_raw && (mispred_q != '1)) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign branch_cnt  = branch_q;
  assign mispred_cnt = mispred_q;
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// Directed self-checking bench for branch_target_predictor (default parameters).
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;
  int          checks = 0;
  int          errors = 0;

  branch_target_predictor dut (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic v, input logic t,
                      input logic [31:0] tgt, input string tag);
    pc_f = pc;
    #1;
    chk({tag, "_valid"}, 32'(pred_valid), 32'(v));
    chk({tag, "_taken"}, 32'(pred_taken), 32'(t));
    chk({tag, "_target"}, pred_target, tgt);
  endtask

  initial begin
    // Reset held with a live mispredicting update: all outputs must stay 0.
    rst = 1'b0; pc_f = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    #7;
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_valid", 32'(pred_valid), 32'd0);
    chk("rst_bcnt", branch_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1; upd_valid = 1'b0;

    look(32'h100, 1'b0, 1'b0, 32'h0, "cold");
    chk("cold_mispredict", 32'(mispredict), 32'd0);

    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    chk("alloc_mispredict", 32'(mispredict), 32'd1);
    chk("alloc_redirect", redirect_pc, 32'h80);
    chk("alloc_nobypass", 32'(pred_valid), 32'd0);
    tick();
    look(32'h100, 1'b1, 1'b1, 32'h80, "alloc");

    // Counter 10 -> 11, target retargeted to 0x90; lookup keeps old target pre-edge.
    upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    chk("tgt_mispredict", 32'(mispredict), 32'd1);
    chk("tgt_redirect", redirect_pc, 32'h90);
    chk("tgt_nobypass", pred_target, 32'h80);
    tick();
    upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
    chk("hit_mispredict", 32'(mispredict), 32'd0);
    tick();
    // Counter held at 11; now walk down: 10, 01, 00, 00.
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h90); tick();
    look(32'h100, 1'b1, 1'b1, 32'h90, "ctr10");
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h90); tick();
    look(32'h100, 1'b1, 1'b0, 32'h90, "ctr01");
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    look(32'h100, 1'b1, 1'b0, 32'h90, "ctr00");
    // One taken from saturated 00 gives 01, still not taken.
    upd(32'h100, 1'b1, 32'h90, 1'b0, 32'h0); tick();
    look(32'h100, 1'b1, 1'b0, 32'h90, "ctr00_up");

    // Alias: 0x140 shares index 0 with 0x100.
    look(32'h140, 1'b0, 1'b0, 32'h0, "alias_miss");
    upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h0); tick();
    look(32'h140, 1'b1, 1'b1, 32'h300, "alias_new");
    look(32'h100, 1'b0, 1'b0, 32'h0, "alias_old");

    // Not-taken misses never allocate.
    upd(32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("nt_mispredict", 32'(mispredict), 32'd0);
    tick();
    look(32'h200, 1'b0, 1'b0, 32'h0, "nt_noalloc");
    upd(32'h200, 1'b0, 32'h0, 1'b1, 32'h208);
    chk("nt_pred_mispredict", 32'(mispredict), 32'd1);
    chk("nt_redirect", redirect_pc, 32'h204);
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("wrap_mispredict", 32'(mispredict), 32'd1);
    chk("wrap_redirect", redirect_pc, 32'h0);
    upd_valid = 1'b0;

    // Fresh stats window: 5 resolved branches, 2 mispredictions.
    rst = 1'b0; #2; rst = 1'b1; #1;
    upd(32'h400, 1'b1, 32'h500, 1'b0, 32'h0);   tick();
    upd(32'h400, 1'b1, 32'h500, 1'b1, 32'h500); tick();
    upd(32'h404, 1'b0, 32'h0,   1'b0, 32'h0);   tick();
    upd(32'h408, 1'b0, 32'h0,   1'b1, 32'h500); tick();
    upd(32'h400, 1'b1, 32'h500, 1'b1, 32'h500); tick();
`ifdef STATS_EN
    chk("stats_branch", branch_cnt, 32'd5);
    chk("stats_mispred", mispred_cnt, 32'd2);
`else
    chk("stats_branch_tied", branch_cnt, 32'd0);
    chk("stats_mispred_tied", mispred_cnt, 32'd0);
`endif
    look(32'h400, 1'b1, 1'b1, 32'h500, "pre_rst");

    // Asynchronous reset mid-cycle clears the table and counters immediately.
    rst = 1'b0;
    look(32'h400, 1'b0, 1'b0, 32'h0, "in_rst");
    chk("in_rst_bcnt", branch_cnt, 32'd0);
    chk("in_rst_mcnt", mispred_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    look(32'h400, 1'b0, 1'b0, 32'h0, "post_rst");
    chk("post_rst_bcnt", branch_cnt, 32'd0);
    chk("post_rst_mcnt", mispred_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
